// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the CPU execute stage, the DMA/debug loader and the DMEM port.
// slave = arbiter side, master = requesters plus memory (bench side).
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [3:0]        cpu_wea;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [3:0]        dma_wea;
    logic              dma_gnt;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_rvalid;

    logic [ADDR_W-1:0] dmem_addra;
    logic [DATA_W-1:0] dmem_dina;
    logic [3:0]        dmem_wea;
    logic [DATA_W-1:0] dmem_douta;

    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_wea,
        input  dma_req, dma_addr, dma_wdata, dma_wea,
        input  dmem_douta,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        output dma_gnt, dma_rdata, dma_rvalid,
        output dmem_addra, dmem_dina, dmem_wea
    );

    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_wea,
        output dma_req, dma_addr, dma_wdata, dma_wea,
        output dmem_douta,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  dmem_addra, dmem_dina, dmem_wea
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-port DMEM arbiter: CPU has fixed priority, the DMA side gets a forced
// one-cycle slot after STARVE_MAX denied cycles; read returns tagged by owner.
module dmem_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic                clk,
    input logic                rst,
    dmem_port_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] wait_cnt;
    logic [1:0] rd_owner_q;
    logic       force_gnt;
    logic       dma_gnt;
    logic       cpu_gnt;

    assign force_gnt = bus.dma_req && (wait_cnt >= STARVE_LIM);
    assign dma_gnt   = bus.dma_req && (force_gnt || !bus.cpu_req);
    assign cpu_gnt   = bus.cpu_req && !dma_gnt;

    assign bus.dma_gnt   = dma_gnt;
    assign bus.cpu_stall = bus.cpu_req && dma_gnt;

    // Idle port drives all zeros so no stale address/data can reach a write.
    always_comb begin
        bus.dmem_addra = '0;
        bus.dmem_dina  = '0;
        bus.dmem_wea   = 4'h0;
        if (dma_gnt) begin
            bus.dmem_addra = bus.dma_addr;
            bus.dmem_dina  = bus.dma_wdata;
            bus.dmem_wea   = bus.dma_wea;
        end else if (cpu_gnt) begin
            bus.dmem_addra = bus.cpu_addr;
            bus.dmem_dina  = bus.cpu_wdata;
            bus.dmem_wea   = bus.cpu_wea;
        end
    end

    // Counter clears on the forced grant itself, so a forced slot lasts one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt   <= 4'h0;
            rd_owner_q <= 2'b00;
        end else begin
            if (bus.dma_req && !dma_gnt) begin
                if (wait_cnt != 4'hF)
                    wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'h0;
            end
            rd_owner_q <= {dma_gnt && (bus.dma_wea == 4'h0),
                           cpu_gnt && (bus.cpu_wea == 4'h0)};
        end
    end

    assign bus.cpu_rvalid = rd_owner_q[0];
    assign bus.dma_rvalid = rd_owner_q[1];
    assign bus.cpu_rdata  = bus.dmem_douta;
    assign bus.dma_rdata  = bus.dmem_douta;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: DMEM model, read-return scoreboard
// keyed by due cycle, and same-cycle checks of grant/stall/DMEM drive.
module tb_dmem_port_arbiter;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    exp_t cpu_q[$];
    exp_t dma_q[$];
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DMEM model: byte-enabled write, 1-cycle read-first synchronous read
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bus.dmem_wea[b]) mem[bus.dmem_addra][b*8 +: 8] <= bus.dmem_dina[b*8 +: 8];
        bus.dmem_douta <= mem[bus.dmem_addra];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic [13:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wea);
        bus.cpu_req = req; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_wea = wea;
    endtask

    task automatic set_dma(input logic req, input logic [13:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wea);
        bus.dma_req = req; bus.dma_addr = addr; bus.dma_wdata = wdata; bus.dma_wea = wea;
    endtask

    // Read-return monitor: every rvalid must match the oldest expected entry and cycle
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (bus.cpu_rvalid) begin
                if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 32'd1, 32'd0);
                else begin
                    e = cpu_q.pop_front();
                    chk("cpu_rvalid_cycle", 32'(cyc), 32'(e.due));
                    chk("cpu_rdata", bus.cpu_rdata, e.data);
                end
            end else if (cpu_q.size() != 0 && cpu_q[0].due <= cyc) begin
                chk("cpu_rvalid_missing", 32'd0, 32'd1);
                void'(cpu_q.pop_front());
            end
            if (bus.dma_rvalid) begin
                if (dma_q.size() == 0) chk("dma_rvalid_unexpected", 32'd1, 32'd0);
                else begin
                    e = dma_q.pop_front();
                    chk("dma_rvalid_cycle", 32'(cyc), 32'(e.due));
                    chk("dma_rdata", bus.dma_rdata, e.data);
                end
            end else if (dma_q.size() != 0 && dma_q[0].due <= cyc) begin
                chk("dma_rvalid_missing", 32'd0, 32'd1);
                void'(dma_q.pop_front());
            end
        end
    end

    initial begin
        mem[14'h0010] = 32'hDEADBEEF;
        mem[14'h0020] = 32'hCAFEF00D;
        set_cpu(1'b0, 14'h0, 32'h0, 4'h0);
        set_dma(1'b0, 14'h0, 32'h0, 4'h0);

        // reset state
        step(); step();
        chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        chk("rst_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
        chk("rst_dmem_wea", 32'(bus.dmem_wea), 32'd0);
        chk("rst_wait_cnt", 32'(dut.wait_cnt), 32'd0);
        rst = 1'b1;
        step();

        // CPU-only reads, back to back
        for (int i = 0; i < 3; i++) begin
            set_cpu(1'b1, 14'h0010, 32'h0, 4'h0);
            cpu_q.push_back('{cyc + 1, 32'hDEADBEEF});
            #1;
            chk("cpu_only_stall", 32'(bus.cpu_stall), 32'd0);
            chk("cpu_only_addr", 32'(bus.dmem_addra), 32'h10);
            chk("cpu_only_wea", 32'(bus.dmem_wea), 32'd0);
            step();
        end
        set_cpu(1'b0, 14'h0, 32'h0, 4'h0);
        step();

        // DMA-only write then read-back
        set_dma(1'b1, 14'h0100, 32'h12345678, 4'hF);
        #1;
        chk("dma_wr_gnt", 32'(bus.dma_gnt), 32'd1);
        chk("dma_wr_wea", 32'(bus.dmem_wea), 32'hF);
        chk("dma_wr_addr", 32'(bus.dmem_addra), 32'h100);
        chk("dma_wr_din", bus.dmem_dina, 32'h12345678);
        chk("dma_wr_stall", 32'(bus.cpu_stall), 32'd0);
        step();
        set_dma(1'b1, 14'h0100, 32'h0, 4'h0);
        dma_q.push_back('{cyc + 1, 32'h12345678});
        #1;
        chk("dma_rd_gnt", 32'(bus.dma_gnt), 32'd1);
        step();
        set_dma(1'b0, 14'h0, 32'h0, 4'h0);
        step();

        // starvation: forced DMA slot every 5th cycle
        set_cpu(1'b1, 14'h0010, 32'h0, 4'h0);
        set_dma(1'b1, 14'h0020, 32'h0, 4'h0);
        for (int k = 0; k < 10; k++) begin
            logic g;
            g = ((k % 5) == 4);
            if (g) dma_q.push_back('{cyc + 1, 32'hCAFEF00D});
            else   cpu_q.push_back('{cyc + 1, 32'hDEADBEEF});
            #1;
            chk($sformatf("starve_gnt_%0d", k), 32'(bus.dma_gnt), 32'(g));
            chk($sformatf("starve_stall_%0d", k), 32'(bus.cpu_stall), 32'(g));
            chk($sformatf("starve_addr_%0d", k), 32'(bus.dmem_addra), g ? 32'h20 : 32'h10);
            step();
        end
        set_cpu(1'b0, 14'h0, 32'h0, 4'h0);
        set_dma(1'b0, 14'h0, 32'h0, 4'h0);
        step();

        // idle: nothing reaches the DMEM port
        set_cpu(1'b0, 14'h0010, 32'hFFFFFFFF, 4'hF);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("idle_wea", 32'(bus.dmem_wea), 32'd0);
            chk("idle_din", bus.dmem_dina, 32'd0);
            chk("idle_addr", 32'(bus.dmem_addra), 32'd0);
            chk("idle_wait_cnt", 32'(dut.wait_cnt), 32'd0);
            step();
        end

        // reset mid-read discards the return
        set_cpu(1'b1, 14'h0010, 32'h0, 4'h0);
        #1;
        chk("rstmid_stall", 32'(bus.cpu_stall), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_rvalid_low", 32'(bus.cpu_rvalid), 32'd0);
        step();
        chk("rstmid_rvalid_after_edge", 32'(bus.cpu_rvalid), 32'd0);
        set_cpu(1'b0, 14'h0, 32'h0, 4'h0);
        rst = 1'b1;
        #1;
        chk("rstmid_wait_cnt", 32'(dut.wait_cnt), 32'd0);
        step();
        chk("rstmid_no_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        set_dma(1'b1, 14'h0200, 32'h0BADF00D, 4'hF);
        #1;
        chk("rstmid_dma_gnt", 32'(bus.dma_gnt), 32'd1);
        step();
        set_dma(1'b0, 14'h0, 32'h0, 4'h0);
        step();

        // mixed: CPU half-word write wins, DMA reads merged word afterwards
        set_cpu(1'b1, 14'h0020, 32'hAAAA5555, 4'b0011);
        set_dma(1'b1, 14'h0020, 32'h0, 4'h0);
        #1;
        chk("mixed_cpu_stall", 32'(bus.cpu_stall), 32'd0);
        chk("mixed_dma_gnt", 32'(bus.dma_gnt), 32'd0);
        chk("mixed_wea", 32'(bus.dmem_wea), 32'h3);
        chk("mixed_din", bus.dmem_dina, 32'hAAAA5555);
        step();
        set_cpu(1'b0, 14'h0, 32'h0, 4'h0);
        dma_q.push_back('{cyc + 1, 32'hCAFE5555});
        #1;
        chk("mixed_dma_gnt2", 32'(bus.dma_gnt), 32'd1);
        step();
        set_dma(1'b0, 14'h0, 32'h0, 4'h0);

        step(); step(); step();
        chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        chk("dma_q_drained", 32'(dma_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory (DMEM, 16K words, 1-cycle synchronous read) between two requesters:
  - the CPU execute stage;
  - a background requester (debug/DMA loader).
- The CPU has fixed priority. A starvation counter forces a one-cycle grant to the DMA side after a bounded wait, and the CPU pipeline is stalled for that cycle.
- Sits between the execute stage's memory-write control and the DMEM instance. It drives the DMEM address, write data and byte enables, and routes read data back with registered valid flags.

Parameters:
- ADDR_W, 14, DMEM word-address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive denied DMA-request cycles before a forced DMA grant (range 1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- cpu_req  input  1  CPU access this cycle.
- cpu_addr  input  ADDR_W  CPU word address.
- cpu_wdata  input  DATA_W  CPU store data, already lane-shifted.
- cpu_wea  input  4  CPU byte enables; 0 means read.
- cpu_stall  output  1  CPU access not serviced this cycle; pipeline must hold.
- cpu_rdata  output  DATA_W  read data to CPU.
- cpu_rvalid  output  1  cpu_rdata valid (read issued previous cycle).
- dma_req  input  1  DMA access request; held until granted.
- dma_addr  input  ADDR_W  DMA word address.
- dma_wdata  input  DATA_W  DMA store data.
- dma_wea  input  4  DMA byte enables; 0 means read.
- dma_gnt  output  1  DMA access performed this cycle.
- dma_rdata  output  DATA_W  read data to DMA.
- dma_rvalid  output  1  dma_rdata valid.
- dmem_addra  output  ADDR_W  DMEM address.
- dmem_dina  output  DATA_W  DMEM write data.
- dmem_wea  output  4  DMEM byte enables.
- dmem_douta  input  DATA_W  DMEM read data, 1-cycle latency.

Behaviour:
- **State**
  - wait_cnt: 4-bit counter.
  - rd_owner_q: 2-bit register; bit0 = CPU read pending, bit1 = DMA read pending.
- **Grant, combinational from current requests and wait_cnt**
  - force = dma_req && (wait_cnt >= STARVE_MAX).
  - dma_gnt = dma_req && (force || !cpu_req).
  - cpu_gnt = cpu_req && !dma_gnt.
  - cpu_stall = cpu_req && dma_gnt.
  - Exactly one or zero grants per cycle.
- **DMEM drive**
  - Granted side's addr, wdata and wea pass straight through in the same cycle.
  - With no grant: dmem_wea = 0, dmem_addra = 0, dmem_dina = 0. No spurious writes.
- **Starvation counter (clocked)**
  - dma_req && !dma_gnt: wait_cnt increments, saturating at 15.
  - Otherwise: wait_cnt clears to 0.
  - A forced grant lasts exactly one cycle, because the counter clears on that grant.
  - Back-to-back DMA requests against a continuous CPU stream therefore give the DMA one slot every STARVE_MAX+1 cycles.
- **Read return (clocked)**
  - rd_owner_q <= {dma_gnt && dma_wea==0, cpu_gnt && cpu_wea==0}.
  - cpu_rvalid = rd_owner_q[0]; dma_rvalid = rd_owner_q[1]. Both are registered outputs.
  - cpu_rdata and dma_rdata both equal dmem_douta; consumers qualify with their rvalid.
  - Writes produce no rvalid.
- **Reset**
  - rst low clears wait_cnt and rd_owner_q immediately, so both rvalids are 0.
  - Combinational outputs follow the inputs; a request asserted during reset is arbitrated normally, but its read return is dropped while rst is low.
  - Reset mid-read discards the pending return; no rvalid is produced after reset releases.
- **Simultaneous events**
  - CPU and DMA request with wait_cnt < STARVE_MAX: CPU wins.
  - Read by one side and write by the other in consecutive cycles is legal; the DMEM port serialises them.
  - A cpu_stall cycle followed by a CPU retry in the next cycle is serviced, since wait_cnt is 0.
- cpu_stall is never asserted when dma_req = 0.

Test Plan:
- **CPU only:** cpu_req=1, cpu_wea=0, addr=0x0010 for 3 cycles, DMEM preloaded 0xDEADBEEF → cpu_stall=0 throughout; cpu_rvalid=1 one cycle after each request; cpu_rdata=0xDEADBEEF.
- **DMA only:** dma_req=1, dma_wea=4'hF, addr=0x0100, wdata=0x12345678 → dma_gnt=1 same cycle; dmem_wea=4'hF; a DMA read of 0x0100 next cycle gives dma_rvalid=1 and dma_rdata=0x12345678.
- **Starvation (STARVE_MAX=4):** cpu_req and dma_req held high → dma_gnt=0 for cycles 0-3; dma_gnt=1 and cpu_stall=1 in cycle 4; pattern repeats with a period of 5.
- **Idle:** both requests low, cpu_wdata=0xFFFFFFFF → dmem_wea=0; no rvalid; wait_cnt stays 0.
- **Reset mid-op:** CPU read granted, then rst driven low before the next rising edge → cpu_rvalid=0; wait_cnt=0 after release; a DMA request after release is granted immediately when cpu_req=0.
- **Mixed:** CPU write 0xAAAA5555 byte-enable 4'b0011 to 0x20 in the same cycle as a DMA read of 0x20 with wait_cnt=0 → CPU write granted, DMA stalled. A later DMA grant then reads the merged word: lower half 0x5555, upper half the preload value.
